fetch_ctrl: RTL and testbench

Fetch-stage controller for the single-issue MIPS pipeline. Owns the PC register and the instruction-memory port: in IDLE it lets an external loader write a program into instruction memory, then on START it sequences instruction fetch into the IF/ID register. While running it handles load-use stalls, taken-branch redirects with a one-slot flush, and a halt sentinel. The instruction memory array itself is external, with combinational read and synchronous write.

---
 rtl/fetch_ctrl.sv | 128 ++++++++++++
 tb/tb_fetch_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC and IF/ID register, steers the instruction-memory
// port between the program loader (IDLE) and instruction fetch (RUN) until a halt sentinel.
module fetch_ctrl #(
  parameter int          IMEM_AW   = 12,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               LOAD_VALID,
  input  logic [31:0]        LOAD_DATA,
  output logic               LOAD_READY,
  input  logic               STALL,
  input  logic               PC_SRC,
  input  logic [31:0]        BRANCH_TARGET,
  input  logic [31:0]        IMEM_RDATA,
  output logic [IMEM_AW-1:0] IMEM_ADDR,
  output logic               IMEM_WE,
  output logic [31:0]        IMEM_WDATA,
  output logic [31:0]        PC,
  output logic [31:0]        CUR_INS,
  output logic [31:0]        NEXT_INS_ADR,
  output logic               IF_VALID,
  output logic               HALTED
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

  localparam logic [IMEM_AW-1:0] LP_LAST = {IMEM_AW{1'b1}};
  localparam logic [IMEM_AW-1:0] LP_ONE  = {{(IMEM_AW-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [IMEM_AW-1:0] lp_r;
  logic               full_r;
  logic [31:0]        pc_r;
  logic [31:0]        cur_ins_r;
  logic [31:0]        next_ins_adr_r;
  logic               if_valid_r;
  logic               halted_r;
  logic               load_ready_s;
  logic               accept_s;
  logic [IMEM_AW-1:0] imem_addr_s;

  // Loader handshake and memory address steering; the fetch address drops high PC bits
  always_comb begin
    load_ready_s = 1'b0;
    imem_addr_s  = pc_r[IMEM_AW+1:2];
    if (state_r == S_IDLE) begin
      load_ready_s = !full_r;
      imem_addr_s  = lp_r;
    end else begin
      load_ready_s = 1'b0;
      imem_addr_s  = pc_r[IMEM_AW+1:2];
    end
  end

  assign accept_s = LOAD_VALID && load_ready_s;

  // Control FSM with PC, IF/ID and load-pointer registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r        <= S_IDLE;
      lp_r           <= {IMEM_AW{1'b0}};
      full_r         <= 1'b0;
      pc_r           <= RESET_PC;
      cur_ins_r      <= 32'd0;
      next_ins_adr_r <= 32'd0;
      if_valid_r     <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (lp_r == LP_LAST) begin
              full_r <= 1'b1;
            end else begin
              lp_r <= lp_r + LP_ONE;
            end
          end else if (START) begin
            state_r <= S_RUN;
            pc_r    <= RESET_PC;
          end
        end
        S_RUN: begin
          if (PC_SRC) begin
            pc_r       <= BRANCH_TARGET & 32'hFFFF_FFFC;
            cur_ins_r  <= 32'd0;
            if_valid_r <= 1'b0;
          end else if (STALL) begin
            // IF/ID and PC hold while the hazard unit stalls
          end else if (IMEM_RDATA == HALT_WORD) begin
            state_r    <= S_HALT;
            cur_ins_r  <= 32'd0;
            if_valid_r <= 1'b0;
            halted_r   <= 1'b1;
          end else begin
            cur_ins_r      <= IMEM_RDATA;
            next_ins_adr_r <= pc_r + 32'd4;
            pc_r           <= pc_r + 32'd4;
            if_valid_r     <= 1'b1;
          end
        end
        S_HALT: begin
          if (START) begin
            state_r  <= S_IDLE;
            lp_r     <= {IMEM_AW{1'b0}};
            full_r   <= 1'b0;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign LOAD_READY   = load_ready_s;
  assign IMEM_ADDR    = imem_addr_s;
  assign IMEM_WE      = accept_s;
  assign IMEM_WDATA   = LOAD_DATA;
  assign PC           = pc_r;
  assign CUR_INS      = cur_ins_r;
  assign NEXT_INS_ADR = next_ins_adr_r;
  assign IF_VALID     = if_valid_r;
  assign HALTED       = halted_r;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus randomized traffic against a
// cycle-level reference model built from the fetch/load/halt rules.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  localparam int          DEPTH  = 4096;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        start = 1'b0, lv = 1'b0, stall = 1'b0, pc_src = 1'b0;
  logic [31:0] ld = 32'd0, bt = 32'd0;
  logic        load_ready, imem_we, if_valid, halted;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata, imem_rdata, pc, cur_ins, nia;
  logic [31:0] imem [0:DEPTH-1];

  // small-memory instance for the full/wrap boundaries
  logic        s_start = 1'b0, s_lv = 1'b0, s_zero = 1'b0;
  logic [31:0] s_ld = 32'd0, s_bt = 32'd0;
  logic        s_ready, s_we, s_valid, s_halted;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata, s_rdata, s_pc, s_cur, s_nia;
  logic [31:0] s_imem [0:3];

  // reference model state
  int          m_st, m_lp, errors = 0, checks = 0;
  logic        m_full, m_valid, m_halted;
  logic [31:0] m_pc, m_cur, m_nia;
  logic [31:0] m_mem [0:DEPTH-1];

  wire [97:0] dut_regs = {pc, cur_ins, nia, if_valid, halted};

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (imem_we) imem[imem_addr] <= imem_wdata;
  assign imem_rdata = imem[imem_addr];
  always @(posedge CLK) if (s_we) s_imem[s_addr] <= s_wdata;
  assign s_rdata = s_imem[s_addr];

  fetch_ctrl dut (
    .CLK(CLK), .RST(RST), .START(start), .LOAD_VALID(lv), .LOAD_DATA(ld), .LOAD_READY(load_ready),
    .STALL(stall), .PC_SRC(pc_src), .BRANCH_TARGET(bt), .IMEM_RDATA(imem_rdata),
    .IMEM_ADDR(imem_addr), .IMEM_WE(imem_we), .IMEM_WDATA(imem_wdata), .PC(pc),
    .CUR_INS(cur_ins), .NEXT_INS_ADR(nia), .IF_VALID(if_valid), .HALTED(halted)
  );

  fetch_ctrl #(.IMEM_AW(2)) dut_s (
    .CLK(CLK), .RST(RST), .START(s_start), .LOAD_VALID(s_lv), .LOAD_DATA(s_ld), .LOAD_READY(s_ready),
    .STALL(s_zero), .PC_SRC(s_zero), .BRANCH_TARGET(s_bt), .IMEM_RDATA(s_rdata),
    .IMEM_ADDR(s_addr), .IMEM_WE(s_we), .IMEM_WDATA(s_wdata), .PC(s_pc),
    .CUR_INS(s_cur), .NEXT_INS_ADR(s_nia), .IF_VALID(s_valid), .HALTED(s_halted)
  );

  function automatic logic [97:0] mdl_regs();
    return {m_pc, m_cur, m_nia, m_valid, m_halted};
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_lp = 0; m_full = 1'b0; m_pc = 32'd0;
    m_cur = 32'd0; m_nia = 32'd0; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // Advance the model by one clock using the currently driven inputs, then cross the edge
  task automatic tick();
    logic [31:0] w;
    case (m_st)
      M_IDLE: begin
        if (lv && !m_full) begin
          m_mem[m_lp] = ld;
          if (m_lp == DEPTH - 1) m_full = 1'b1;
          else m_lp = m_lp + 1;
        end else if (start) begin
          m_st = M_RUN; m_pc = 32'd0;
        end
      end
      M_RUN: begin
        if (pc_src) begin
          m_pc = bt - (bt % 32'd4); m_cur = 32'd0; m_valid = 1'b0;
        end else if (!stall) begin
          w = m_mem[(m_pc / 32'd4) % 32'd4096];
          if (w == HALT_W) begin
            m_st = M_HALT; m_cur = 32'd0; m_valid = 1'b0; m_halted = 1'b1;
          end else begin
            m_cur = w; m_nia = m_pc + 32'd4; m_pc = m_pc + 32'd4; m_valid = 1'b1;
          end
        end
      end
      default: begin
        if (start) begin
          m_st = M_IDLE; m_lp = 0; m_full = 1'b0; m_pc = 32'd0; m_halted = 1'b0;
        end
      end
    endcase
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1 RST = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_regs !== mdl_regs() || load_ready !== 1'b1 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got %h rdy=%b we=%b, expected %h rdy=1 we=0", dut_regs, load_ready, imem_we, mdl_regs());
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
  endtask

  task automatic test_load_run();
    logic [31:0] words [3];
    words[0] = 32'h2009_0002; words[1] = 32'h0129_4820; words[2] = HALT_W;
    for (int i = 0; i < 3; i++) begin
      lv = 1'b1; ld = words[i];
      #1;
      checks++;
      if (load_ready !== 1'b1 || imem_we !== 1'b1 || imem_addr !== 12'(i)) begin
        errors++;
        $display("FAIL load_write[%0d]: rdy=%b we=%b addr=%0d, expected 1 1 %0d", i, load_ready, imem_we, imem_addr, i);
      end
      tick();
    end
    lv = 1'b0; start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (imem[0] !== words[0] || imem[1] !== words[1] || imem[2] !== words[2] || pc !== 32'd0 || if_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_contents: mem=%h %h %h pc=%h v=%b", imem[0], imem[1], imem[2], pc, if_valid);
    end
    tick();
    checks++;
    if (cur_ins !== 32'h2009_0002 || nia !== 32'd4 || if_valid !== 1'b1 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL first_fetch: got %h, expected %h", dut_regs, mdl_regs());
    end
    tick();
    checks++;
    if (cur_ins !== 32'h0129_4820 || nia !== 32'd8 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL second_fetch: got %h, expected %h", dut_regs, mdl_regs());
    end
    tick();
    checks++;
    if (halted !== 1'b1 || pc !== 32'd8 || if_valid !== 1'b0 || cur_ins !== 32'd0) begin
      errors++;
      $display("FAIL halt_stop: h=%b pc=%h v=%b ins=%h, expected 1 00000008 0 00000000", halted, pc, if_valid, cur_ins);
    end
  endtask

  task automatic test_restart();
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (halted !== 1'b0 || load_ready !== 1'b1 || imem_addr !== 12'd0 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL restart_idle: h=%b rdy=%b addr=%0d regs=%h, expected 0 1 0 %h", halted, load_ready, imem_addr, dut_regs, mdl_regs());
    end
    for (int i = 0; i < 21; i++) begin
      lv = 1'b1; ld = (i == 20) ? HALT_W : 32'h2000_0000 + 32'(i);
      #1;
      checks++;
      if (imem_addr !== 12'(i) || imem_we !== 1'b1) begin
        errors++;
        $display("FAIL reload_addr[%0d]: addr=%0d we=%b, expected %0d 1", i, imem_addr, imem_we, i);
      end
      tick();
    end
    lv = 1'b0; start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (cur_ins !== 32'h2000_0000 || if_valid !== 1'b1 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL restart_fetch: got %h, expected %h", dut_regs, mdl_regs());
    end
  endtask

  task automatic test_stall();
    logic [97:0] snap;
    for (int i = 0; i < 3; i++) tick();
    snap = mdl_regs();
    checks++;
    if (pc !== 32'h10 || dut_regs !== snap) begin
      errors++;
      $display("FAIL pre_stall: got %h, expected %h", dut_regs, snap);
    end
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (dut_regs !== snap) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got %h, expected %h", k, dut_regs, snap);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if (cur_ins !== 32'h2000_0004 || nia !== 32'h14 || pc !== 32'h14) begin
      errors++;
      $display("FAIL stall_resume: ins=%h nia=%h pc=%h, expected 20000004 00000014 00000014", cur_ins, nia, pc);
    end
  endtask

  task automatic test_redirect();
    pc_src = 1'b1; stall = 1'b1; bt = 32'h43;
    tick();
    pc_src = 1'b0; stall = 1'b0; bt = 32'd0;
    checks++;
    if (pc !== 32'h40 || cur_ins !== 32'd0 || if_valid !== 1'b0 || nia !== 32'h14) begin
      errors++;
      $display("FAIL redirect_bubble: pc=%h ins=%h v=%b nia=%h, expected 00000040 00000000 0 00000014", pc, cur_ins, if_valid, nia);
    end
    tick();
    checks++;
    if (cur_ins !== 32'h2000_0010 || nia !== 32'h44 || if_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_target: ins=%h nia=%h v=%b, expected 20000010 00000044 1", cur_ins, nia, if_valid);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (halted !== 1'b1 || pc !== 32'h50 || if_valid !== 1'b0 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL redirect_halt: got %h, expected %h", dut_regs, mdl_regs());
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1; tick(); tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (pc !== 32'h24 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL pre_reset_run: got %h, expected %h", dut_regs, mdl_regs());
    end
    #2 RST = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_regs !== {32'd0, 32'd0, 32'd0, 1'b0, 1'b0} || load_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got %h rdy=%b, expected all-zero rdy=1", dut_regs, load_ready);
    end
    @(negedge CLK);
    RST = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    checks++;
    if (cur_ins !== 32'h2000_0000 || nia !== 32'd4 || dut_regs !== mdl_regs()) begin
      errors++;
      $display("FAIL refetch_after_reset: got %h, expected %h", dut_regs, mdl_regs());
    end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 5; i++) begin
      s_lv = 1'b1; s_ld = 32'h3000_0000 + 32'(i);
      #1;
      checks++;
      if (s_ready !== (i < 4) || s_we !== (i < 4)) begin
        errors++;
        $display("FAIL full_ready[%0d]: rdy=%b we=%b, expected %b", i, s_ready, s_we, (i < 4));
      end
      tick();
    end
    s_lv = 1'b0; s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (s_pc !== 32'h10 || s_addr !== 2'd0 || s_imem[0] !== 32'h3000_0000 || s_imem[3] !== 32'h3000_0003) begin
      errors++;
      $display("FAIL wrap_addr: pc=%h addr=%0d mem0=%h mem3=%h, expected 00000010 0 30000000 30000003", s_pc, s_addr, s_imem[0], s_imem[3]);
    end
    tick();
    checks++;
    if (s_cur !== 32'h3000_0000 || s_nia !== 32'h14) begin
      errors++;
      $display("FAIL wrap_fetch: ins=%h nia=%h, expected 30000000 00000014", s_cur, s_nia);
    end
  endtask

  task automatic test_random();
    logic [13:0] exp_port;
    for (int n = 0; n < 1500; n++) begin
      lv = 1'b0; start = 1'b0; stall = 1'b0; pc_src = 1'b0; bt = 32'd0; ld = 32'd0;
      case (m_st)
        M_IDLE: begin
          lv = ($urandom_range(0, 3) != 0);
          ld = ($urandom_range(0, 7) == 0) ? HALT_W : $urandom;
          start = ($urandom_range(0, 9) == 0);
        end
        M_RUN: begin
          stall = ($urandom_range(0, 3) == 0);
          pc_src = ($urandom_range(0, 7) == 0);
          bt = $urandom_range(0, 127);
        end
        default: start = ($urandom_range(0, 3) == 0);
      endcase
      #1;
      if (m_st != M_HALT) begin
        if (m_st == M_IDLE) exp_port = {!m_full, lv && !m_full, 12'(m_lp)};
        else exp_port = {1'b0, 1'b0, 12'((m_pc / 32'd4) % 32'd4096)};
        checks++;
        if ({load_ready, imem_we, imem_addr} !== exp_port) begin
          errors++;
          $display("FAIL rand_port[%0d]: got %h, expected %h", n, {load_ready, imem_we, imem_addr}, exp_port);
        end
      end
      tick();
      checks++;
      if (dut_regs !== mdl_regs()) begin
        errors++;
        $display("FAIL rand_regs[%0d]: got %h, expected %h", n, dut_regs, mdl_regs());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      imem[i] <= 32'd0;
      m_mem[i] = 32'd0;
    end
    for (int i = 0; i < 4; i++) s_imem[i] <= 32'd0;
    model_reset();
    test_reset();
    test_load_run();
    test_restart();
    test_stall();
    test_redirect();
    test_reset_mid_run();
    test_full_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
